dsp_unit_mc: RTL
================

# dsp_unit_mc

Parametrised multichannel successor to the audioport DSP stage. It filters CHANNELS audio streams through a TAPS-tap FIR with a shared coefficient bank, using one sequential multiply-accumulate per cycle. Each result is scaled by a per-channel level gain and saturated. It sits between the audioport control/register block (tick, cfg, level, clr strobes and register images) and the I2S output stage, and emits one `tick_out` per processed sample frame.

## Interface
- `CHANNELS`, 2: number of audio channels (≥1)
- `DATA_W`, 24: signed sample width
- `TAPS`, 8: FIR taps per channel (≥1)
- `COEF_W`, 32: signed Q1.(COEF_W-1) coefficient width
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `tick_in`  in  1  one-cycle strobe: new input frame valid
- `cfg_in`  in  1  strobe: latch `cfg_reg_in`
- `level_in`  in  1  strobe: latch `level_reg_in`
- `clr_in`  in  1  strobe: clear datapath
- `audio_in`  in  CHANNELS*DATA_W  channel c at bits [c*DATA_W +: DATA_W]
- `dsp_regs_in`  in  TAPS*COEF_W  coefficient k at [k*COEF_W +: COEF_W]; k=0 applies to the newest sample
- `level_reg_in`  in  CHANNELS*16  unsigned Q1.15 gain per channel (0x8000 = 1.0)
- `cfg_reg_in`  in  32  bit0 = filter enable; other bits reserved
- `audio_out`  out  CHANNELS*DATA_W  processed frame
- `tick_out`  out  1  one-cycle strobe: `audio_out` updated
- `busy_out`  out  1  computation in progress
- `overrun_out`  out  1  sticky: a tick arrived while busy

## Operation
- State machine: IDLE → MAC → SCALE → OUT → IDLE.
- IDLE with `tick_in`: shift each channel's delay line (depth TAPS), insert `audio_in` at position 0, clear the accumulator, and enter MAC.
- MAC: one product per cycle, channel-major (c=0 taps 0..TAPS-1, then c=1, …). Stay for CHANNELS*TAPS cycles.
- Filter enabled: acc += x[c][k]*coef[k]. Accumulator width DATA_W+COEF_W+clog2(TAPS).
- Filter disabled (bypass): the term is x[c][0]<<(COEF_W-1) for k=0 and 0 for other taps. Schedule and latency are unchanged.
- End of each channel: y = acc >>> (COEF_W-1), saturated to DATA_W. Store y and clear acc.
- SCALE: z[c] = (y[c]*gain[c]) >>> 15, saturated to DATA_W; all channels in parallel.
- OUT: register z into `audio_out`, pulse `tick_out`, return to IDLE.
- Saturation limits: 2^(DATA_W-1)-1 and -2^(DATA_W-1). Without the rounding macro, shifts truncate toward −∞.
- `cfg_in` / `level_in`: the register image is latched the next edge in any state. The MAC and SCALE paths use the value latched at the start of the current frame, so a frame never mixes settings.
- `tick_in` while not IDLE: the tick is dropped, the frame is ignored, and `overrun_out` is set.
- `clr_in` has the highest priority, above a simultaneous `tick_in`. Next edge:
  - delay lines, accumulator and `audio_out` go to 0
  - `overrun_out` goes to 0 and state goes to IDLE
  - no `tick_out` for the aborted frame
  - latched cfg and level registers are kept
- `rst` clears everything: cfg is 0 (bypass) and all gains are 0x8000.

## Timing
- Reset values: `audio_out`=0, `tick_out`=0, `busy_out`=0, `overrun_out`=0.
- `tick_in` sampled high at edge 0 gives `tick_out` high for exactly the cycle after edge L = CHANNELS*TAPS+2, with `audio_out` valid from that edge.
- `busy_out` is high from edge 0 through the cycle `tick_out` is high.
- Minimum tick spacing is L+1 cycles; a tick exactly L+1 cycles later is accepted.
- `rst` asserted mid-frame: outputs take reset values at the next edge.

## Configuration
- `DSP_UNIT_MC_ROUND_EN` defined: both right shifts add 2^(shift-1) before shifting (round half up), then saturate.
- Not defined: pure arithmetic-shift truncation.
- Latency is identical in both builds.

## Test plan
All scenarios use CHANNELS=2, TAPS=8, DATA_W=24, COEF_W=32, so L=18.
- Reset: assert `rst` 2 cycles → all outputs 0, a following tick produces bypass behaviour.
- Impulse: filter on, coef0=0x40000000, others 0, gains 0x8000, audio ch0=0x100000, ch1=0xF00000 → 18 cycles later `audio_out` ch0=0x080000, ch1=0xF80000, single-cycle `tick_out`.
- Saturation: all coefs 0x7FFFFFFF, 8 ticks of ch0=0x7FFFFF / ch1=0x800000 → outputs 0x7FFFFF / 0x800000.
- Bypass + level: cfg=0, gain ch0=0x4000, audio 0x200000 → 0x100000 after 18 cycles; a level change mid-frame does not affect that frame.
- Overrun: second tick 5 cycles after the first → frame dropped, one `tick_out`, `overrun_out`=1 until `clr_in`.
- Clear mid-frame: `clr_in` at cycle 7 of MAC → next cycle `busy_out`=0, `audio_out`=0, no `tick_out`; the next tick sees zeroed delay lines.

Source files
------------

// File: rtl/dsp_unit_mc.sv
// -----------------------------------------------------------------------------
// dsp_unit_mc
//
// Multichannel FIR + level stage between the audioport register block and
// the I2S output. For each accepted input frame it runs one multiply-
// accumulate per cycle over all channels (channel-major, taps 0..TAPS-1),
// scales every channel result by its Q1.15 gain, saturates, and presents
// the frame on audio_out with a one-cycle tick_out.
//
// Frame timing: tick_in sampled at edge 0 -> tick_out high for the cycle
// after edge CHANNELS*TAPS+2, audio_out valid from that edge.
//
// Handshake: tick_in is a one-cycle valid strobe with no ready. The
// producer must respect the frame spacing; busy_out is advisory only. A
// tick that arrives outside IDLE is discarded and raises the sticky
// overrun_out flag, which only rst or clr_in can clear.
//
// Build option:
//   DSP_UNIT_MC_ROUND_EN  defined -> both right shifts round half up
//                         undefined -> both right shifts truncate (floor)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tick_in         new input frame strobe
//   cfg_in          latch cfg_reg_in (bit0 = filter enable)
//   level_in        latch level_reg_in (unsigned Q1.15 gain per channel)
//   clr_in          abort frame, zero delay lines / accumulator / output
//   audio_in        CHANNELS x DATA_W signed samples, ch c at [c*DATA_W +: DATA_W]
//   dsp_regs_in     TAPS x COEF_W signed Q1.(COEF_W-1) coefficients, k=0 newest
//   level_reg_in    CHANNELS x 16 gain image
//   cfg_reg_in      32-bit configuration image
//   audio_out       processed frame
//   tick_out        one-cycle strobe, audio_out updated
//   busy_out        frame computation in progress
//   overrun_out     sticky: tick received while not idle
//   state_dbg       current FSM state (IDLE=0, MAC=1, SCALE=2, OUT=3)
// -----------------------------------------------------------------------------
module dsp_unit_mc #(
   parameter int CHANNELS = 2,
   parameter int DATA_W   = 24,
   parameter int TAPS     = 8,
   parameter int COEF_W   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick_in,
   input  logic                       cfg_in,
   input  logic                       level_in,
   input  logic                       clr_in,
   input  logic [CHANNELS*DATA_W-1:0] audio_in,
   input  logic [TAPS*COEF_W-1:0]     dsp_regs_in,
   input  logic [CHANNELS*16-1:0]     level_reg_in,
   input  logic [31:0]                cfg_reg_in,
   output logic [CHANNELS*DATA_W-1:0] audio_out,
   output logic                       tick_out,
   output logic                       busy_out,
   output logic                       overrun_out,
   output logic [1:0]                 state_dbg
);

   localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
   localparam int PROD_W = DATA_W + COEF_W;
   // y (DATA_W signed) times zero-extended 16-bit gain
   localparam int SCL_W  = DATA_W + 17;
   // Common width for rounding/saturation, always wider than both sources
   localparam int SAT_W  = (ACC_W > SCL_W) ? ACC_W + 1 : SCL_W + 1;
   localparam int CH_IW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int TAP_IW = (TAPS > 1) ? $clog2(TAPS) : 1;

   localparam logic signed [SAT_W-1:0] SAT_MAX =
      {{(SAT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [SAT_W-1:0] SAT_MIN =
      {{(SAT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [SAT_W-1:0] SAT_ONE = {{(SAT_W-1){1'b0}}, 1'b1};

`ifdef DSP_UNIT_MC_ROUND_EN
   // Half an LSB of the shifted result, added before the arithmetic shift
   localparam logic signed [SAT_W-1:0] ACC_RND = SAT_ONE << (COEF_W-2);
   localparam logic signed [SAT_W-1:0] SCL_RND = SAT_ONE << 14;
`else
   localparam logic signed [SAT_W-1:0] ACC_RND = '0;
   localparam logic signed [SAT_W-1:0] SCL_RND = '0;
   logic unused_rnd_one;
   assign unused_rnd_one = ^SAT_ONE;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MAC   = 2'd1,
      S_SCALE = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state_q, state_d;
   logic   accept;
   logic   last_tap, last_ch;

   // Live register images and the per-frame snapshot used by MAC/SCALE
   logic                   cfg_en_q;
   logic [CHANNELS*16-1:0] level_q;
   logic                   frm_en;
   logic [CHANNELS*16-1:0] frm_level;

   logic signed [DATA_W-1:0] x_dl [CHANNELS][TAPS];
   logic signed [DATA_W-1:0] y_q  [CHANNELS];
   logic signed [DATA_W-1:0] z_q  [CHANNELS];
   logic signed [ACC_W-1:0]  acc_q;
   logic [CH_IW-1:0]         ch_idx;
   logic [TAP_IW-1:0]        tap_idx;
   logic                     overrun_q;
   logic                     tick_q;

   // MAC datapath
   logic [DATA_W-1:0]        x_sel;
   logic [COEF_W-1:0]        coef_sel;
   logic [PROD_W-1:0]        mul_a, mul_b, term;
   logic signed [SAT_W-1:0]  term_ext, acc_ext, acc_sum, y_rnd;
   logic [DATA_W-1:0]        y_new;

   // SCALE datapath
   logic [SCL_W-1:0]         scl_y [CHANNELS];
   logic [SCL_W-1:0]         scl_g [CHANNELS];
   logic [SCL_W-1:0]         scl_p [CHANNELS];
   logic signed [SAT_W-1:0]  scl_ext [CHANNELS];
   logic [DATA_W-1:0]        z_new [CHANNELS];

   // Only the enable bit of the configuration image is defined
   logic unused_cfg_bits;
   assign unused_cfg_bits = ^cfg_reg_in[31:1];

   function automatic logic [DATA_W-1:0] sat_data(input logic signed [SAT_W-1:0] v);
      if (v > SAT_MAX) begin
         return SAT_MAX[DATA_W-1:0];
      end else if (v < SAT_MIN) begin
         return SAT_MIN[DATA_W-1:0];
      end else begin
         return v[DATA_W-1:0];
      end
   endfunction

   assign last_tap = (tap_idx == TAP_IW'(TAPS-1));
   assign last_ch  = (ch_idx == CH_IW'(CHANNELS-1));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst || clr_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (tick_in) begin
               accept  = 1'b1;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            if (last_tap && last_ch) begin
               state_d = S_SCALE;
            end
         end
         S_SCALE: state_d = S_OUT;
         S_OUT:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign state_dbg   = state_q;
   assign busy_out    = (state_q != S_IDLE) || tick_q;
   assign tick_out    = tick_q;
   assign overrun_out = overrun_q;

   // --------------------------------------------------------- MAC term
   always_comb begin
      x_sel    = x_dl[ch_idx][tap_idx];
      coef_sel = dsp_regs_in[int'(tap_idx)*COEF_W +: COEF_W];
      mul_a    = {{COEF_W{x_sel[DATA_W-1]}}, x_sel};
      mul_b    = {{DATA_W{coef_sel[COEF_W-1]}}, coef_sel};
      term     = '0;
      if (frm_en) begin
         term = mul_a * mul_b;
      end else if (tap_idx == '0) begin
         // Bypass: newest sample at unity gain in the coefficient's Q format
         term = {x_sel[DATA_W-1], x_sel, {(COEF_W-1){1'b0}}};
      end
      term_ext = {{(SAT_W-PROD_W){term[PROD_W-1]}}, term};
      acc_ext  = {{(SAT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
      acc_sum  = acc_ext + term_ext;
      y_rnd    = (acc_sum + ACC_RND) >>> (COEF_W-1);
      y_new    = sat_data(y_rnd);
   end

   // ------------------------------------------------------- SCALE path
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         scl_y[c]   = {{17{y_q[c][DATA_W-1]}}, y_q[c]};
         scl_g[c]   = {{(DATA_W+1){1'b0}}, frm_level[c*16 +: 16]};
         scl_p[c]   = scl_y[c] * scl_g[c];
         scl_ext[c] = {{(SAT_W-SCL_W){scl_p[c][SCL_W-1]}}, scl_p[c]};
         z_new[c]   = sat_data((scl_ext[c] + SCL_RND) >>> 15);
      end
   end

   // ------------------------------------------- register images (kept on clr)
   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_en_q  <= 1'b0;
         level_q   <= {CHANNELS{16'h8000}};
         frm_en    <= 1'b0;
         frm_level <= {CHANNELS{16'h8000}};
      end else begin
         if (cfg_in) begin
            cfg_en_q <= cfg_reg_in[0];
         end
         if (level_in) begin
            level_q <= level_reg_in;
         end
         // Snapshot taken as the frame is accepted; later strobes wait
         // for the next frame.
         if (accept && !clr_in) begin
            frm_en    <= cfg_en_q;
            frm_level <= level_q;
         end
      end
   end

   // ---------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst || clr_in) begin
         for (int c = 0; c < CHANNELS; c++) begin
            for (int k = 0; k < TAPS; k++) begin
               x_dl[c][k] <= '0;
            end
            y_q[c] <= '0;
            z_q[c] <= '0;
         end
         acc_q     <= '0;
         ch_idx    <= '0;
         tap_idx   <= '0;
         audio_out <= '0;
         tick_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (tick_in && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     for (int k = TAPS-1; k > 0; k--) begin
                        x_dl[c][k] <= x_dl[c][k-1];
                     end
                     x_dl[c][0] <= audio_in[c*DATA_W +: DATA_W];
                  end
                  acc_q   <= '0;
                  ch_idx  <= '0;
                  tap_idx <= '0;
               end
            end
            S_MAC: begin
               if (last_tap) begin
                  y_q[ch_idx] <= y_new;
                  acc_q       <= '0;
                  tap_idx     <= '0;
                  ch_idx      <= last_ch ? '0 : ch_idx + 1'b1;
               end else begin
                  acc_q   <= acc_sum[ACC_W-1:0];
                  tap_idx <= tap_idx + 1'b1;
               end
            end
            S_SCALE: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  z_q[c] <= z_new[c];
               end
            end
            S_OUT: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  audio_out[c*DATA_W +: DATA_W] <= z_q[c];
               end
               tick_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
